// File: rtl/alu_load_ctrl_pkg.sv
// Shared definitions for the ALU front-end sequencer: FSM state encoding and ALU opcodes.
package alu_load_ctrl_pkg;

  // state      | meaning
  // LOAD_A  0  | waiting for load to capture operand A
  // LOAD_B  1  | waiting for load to capture operand B
  // LOAD_OP 2  | waiting for load to capture the opcode
  // EXEC    3  | one-cycle execute strobe, result latched at end of cycle
  // DONE    4  | result held on LEDs, next load starts a new sequence
  typedef enum logic [2:0] {
    ST_LOAD_A  = 3'd0,
    ST_LOAD_B  = 3'd1,
    ST_LOAD_OP = 3'd2,
    ST_EXEC    = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;
  localparam logic [5:0] OP_NOR = 6'b100111;

endpackage

// File: rtl/alu_load_ctrl_btn_debounce.sv
// Button conditioner: 2-FF synchronizer, stability down-counter, and a
// one-cycle pulse on each rising edge of the accepted level.
module alu_load_ctrl_btn_debounce #(
  parameter int DB_CYCLES = 4
) (
  input  logic clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_pulse
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(DB_CYCLES - 1);

  logic [1:0]    sync;
  logic          level;
  logic          level_q;
  logic [CW-1:0] cnt;

  // The counter reloads whenever the synced level agrees with the accepted
  // one, so only DB_CYCLES consecutive disagreeing cycles flip the level.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync    <= '0;
      level   <= 1'b0;
      level_q <= 1'b0;
      cnt     <= CNT_LOAD;
    end else begin
      sync    <= {sync[0], i_btn};
      level_q <= level;
      if (sync[1] == level) begin
        cnt <= CNT_LOAD;
      end else if (cnt == '0) begin
        level <= sync[1];
        cnt   <= CNT_LOAD;
      end else begin
        cnt <= cnt - CW'(1);
      end
    end
  end

  assign o_pulse = level & ~level_q;

endmodule

// File: rtl/alu_load_ctrl.sv
// Sequencer that loads operand A, operand B and opcode from switches on
// debounced button presses, strobes the ALU once and latches its result.
module alu_load_ctrl
  import alu_load_ctrl_pkg::*;
#(
  parameter int NB_DATA   = 4,
  parameter int NB_OP     = 6,
  parameter int NB_SW     = 8,
  parameter int DB_CYCLES = 4
) (
  input  logic               clk,
  input  logic               i_rst_n,
  input  logic [NB_SW-1:0]   i_sw,
  input  logic               i_btn_load,
  input  logic               i_btn_clr,
  input  logic [NB_DATA-1:0] i_alu_result,
  output logic [NB_DATA-1:0] o_datoA,
  output logic [NB_DATA-1:0] o_datoB,
  output logic [NB_OP-1:0]   o_operation,
  output logic               o_valid,
  output logic [NB_DATA-1:0] o_leds,
  output logic [2:0]         o_state
);

  logic load;
  logic clr;

  alu_load_ctrl_btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_load (
    .clk     (clk),
    .i_rst_n (i_rst_n),
    .i_btn   (i_btn_load),
    .o_pulse (load)
  );

  alu_load_ctrl_btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_clr (
    .clk     (clk),
    .i_rst_n (i_rst_n),
    .i_btn   (i_btn_clr),
    .o_pulse (clr)
  );

  state_t             state, state_d;
  logic [NB_DATA-1:0] a, a_d, b, b_d, leds, leds_d;
  logic [NB_OP-1:0]   op, op_d;
  logic               clr_pend, clr_pend_d;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= ST_LOAD_A;
      a        <= '0;
      b        <= '0;
      op       <= '0;
      leds     <= '0;
      clr_pend <= 1'b0;
    end else begin
      state    <= state_d;
      a        <= a_d;
      b        <= b_d;
      op       <= op_d;
      leds     <= leds_d;
      clr_pend <= clr_pend_d;
    end
  end

  always_comb begin
    state_d    = state;
    a_d        = a;
    b_d        = b;
    op_d       = op;
    leds_d     = leds;
    clr_pend_d = 1'b0;
    case (state)
      ST_LOAD_A: if (load) begin
        a_d     = i_sw[NB_DATA-1:0];
        state_d = ST_LOAD_B;
      end
      ST_LOAD_B: if (load) begin
        b_d     = i_sw[NB_DATA-1:0];
        state_d = ST_LOAD_OP;
      end
      ST_LOAD_OP: if (load) begin
        op_d    = i_sw[NB_OP-1:0];
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        leds_d     = i_alu_result;
        state_d    = ST_DONE;
        clr_pend_d = clr;
      end
      ST_DONE: if (load) begin
        a_d     = i_sw[NB_DATA-1:0];
        state_d = ST_LOAD_B;
      end
      default: state_d = ST_LOAD_A;
    endcase
    // A clear seen during EXEC is held over and applied in DONE; clear beats load.
    if ((clr && state != ST_EXEC) || clr_pend) begin
      a_d     = '0;
      b_d     = '0;
      op_d    = '0;
      leds_d  = '0;
      state_d = ST_LOAD_A;
    end
  end

  logic unused_sw;
  assign unused_sw = ^i_sw;

  assign o_datoA     = a;
  assign o_datoB     = b;
  assign o_operation = op;
  assign o_leds      = leds;
  assign o_valid     = (state == ST_EXEC);
  assign o_state     = state;

endmodule

// File: tb/tb_alu_load_ctrl.sv
// Directed bench for alu_load_ctrl with a behavioural ALU on its operand outputs.
module tb_alu_load_ctrl;
  import alu_load_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] sw;
  logic       btn_load;
  logic       btn_clr;
  logic [3:0] alu_result;
  logic [3:0] dato_a;
  logic [3:0] dato_b;
  logic [5:0] operation;
  logic       valid;
  logic [3:0] leds;
  logic [2:0] state;

  int n_tests = 0;
  int n_fail  = 0;
  int n_valid = 0;
  int valid_snap;
  logic found;

  always #5 clk = ~clk;

  alu_load_ctrl #(
    .NB_DATA(4), .NB_OP(6), .NB_SW(8), .DB_CYCLES(4)
  ) dut (
    .clk          (clk),
    .i_rst_n      (rst_n),
    .i_sw         (sw),
    .i_btn_load   (btn_load),
    .i_btn_clr    (btn_clr),
    .i_alu_result (alu_result),
    .o_datoA      (dato_a),
    .o_datoB      (dato_b),
    .o_operation  (operation),
    .o_valid      (valid),
    .o_leds       (leds),
    .o_state      (state)
  );

  always_comb begin
    alu_result = 4'd0;
    case (operation)
      OP_ADD: alu_result = dato_a + dato_b;
      OP_SUB: alu_result = dato_a - dato_b;
      OP_AND: alu_result = dato_a & dato_b;
      OP_OR:  alu_result = dato_a | dato_b;
      OP_XOR: alu_result = dato_a ^ dato_b;
      OP_SRA: alu_result = 4'($signed(dato_a) >>> dato_b);
      OP_SRL: alu_result = dato_a >> dato_b;
      OP_NOR: alu_result = ~(dato_a | dato_b);
      default: alu_result = 4'd0;
    endcase
  end

  always @(negedge clk) if (valid === 1'b1) n_valid++;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic press_load(input logic [7:0] val);
    sw = val;
    btn_load = 1'b1;
    repeat (10) @(negedge clk);
    btn_load = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic press_clr();
    btn_clr = 1'b1;
    repeat (10) @(negedge clk);
    btn_clr = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic wait_exec(output logic hit);
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(negedge clk);
      if (state == 3'd3) hit = 1'b1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; sw = 8'd0; btn_load = 1'b0; btn_clr = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_state", {5'd0, state}, 8'd0);
    check("rst_valid", {7'd0, valid}, 8'd0);
    check("rst_leds",  {4'd0, leds}, 8'd0);
    check("rst_a",     {4'd0, dato_a}, 8'd0);
    check("rst_b",     {4'd0, dato_b}, 8'd0);
    check("rst_op",    {2'd0, operation}, 8'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // 1: 3 + 5
    press_load(8'd3);
    check("t1_a", {4'd0, dato_a}, 8'd3);
    check("t1_state_b", {5'd0, state}, 8'd1);
    press_load(8'd5);
    check("t1_b", {4'd0, dato_b}, 8'd5);
    check("t1_state_op", {5'd0, state}, 8'd2);
    valid_snap = n_valid;
    press_load({2'b00, OP_ADD});
    check("t1_op", {2'd0, operation}, {2'd0, OP_ADD});
    check("t1_valid_cycles", 8'(n_valid - valid_snap), 8'd1);
    check("t1_leds", {4'd0, leds}, 8'b0000_1000);
    check("t1_state_done", {5'd0, state}, 8'd4);

    // 2: from DONE, 6 - 3
    press_load(8'd6);
    check("t2_a", {4'd0, dato_a}, 8'd6);
    check("t2_state", {5'd0, state}, 8'd1);
    check("t2_b_kept", {4'd0, dato_b}, 8'd5);
    check("t2_leds_hold", {4'd0, leds}, 8'd8);
    press_load(8'd3);
    valid_snap = n_valid;
    press_load({2'b00, OP_SUB});
    check("t2_valid_cycles", 8'(n_valid - valid_snap), 8'd1);
    check("t2_leds", {4'd0, leds}, 8'b0000_0011);
    check("t2_state_done", {5'd0, state}, 8'd4);

    // 3: clear, glitch, long hold
    press_clr();
    check("t3_clr_state", {5'd0, state}, 8'd0);
    check("t3_clr_leds", {4'd0, leds}, 8'd0);
    check("t3_clr_op", {2'd0, operation}, 8'd0);
    sw = 8'd9;
    btn_load = 1'b1;
    repeat (2) @(negedge clk);
    btn_load = 1'b0;
    repeat (10) @(negedge clk);
    check("t3_glitch_state", {5'd0, state}, 8'd0);
    check("t3_glitch_a", {4'd0, dato_a}, 8'd0);
    sw = 8'b0000_1100;
    btn_load = 1'b1;
    repeat (50) @(negedge clk);
    btn_load = 1'b0;
    repeat (10) @(negedge clk);
    check("t3_hold_state", {5'd0, state}, 8'd1);
    check("t3_hold_a", {4'd0, dato_a}, 8'b0000_1100);

    // 4: clear in LOAD_B, then load and clear together
    press_clr();
    check("t4_clr_a", {4'd0, dato_a}, 8'd0);
    check("t4_clr_state", {5'd0, state}, 8'd0);
    sw = 8'd7;
    btn_load = 1'b1;
    btn_clr = 1'b1;
    repeat (10) @(negedge clk);
    btn_load = 1'b0;
    btn_clr = 1'b0;
    repeat (10) @(negedge clk);
    check("t4_both_state", {5'd0, state}, 8'd0);
    check("t4_both_a", {4'd0, dato_a}, 8'd0);

    // 5: reset during EXEC
    press_load(8'd1);
    press_load(8'd2);
    press_load({2'b00, OP_ADD});
    check("t5_first_leds", {4'd0, leds}, 8'd3);
    press_load(8'd4);
    press_load(8'd4);
    sw = {2'b00, OP_ADD};
    btn_load = 1'b1;
    wait_exec(found);
    check("t5_exec_reached", {7'd0, found}, 8'd1);
    check("t5_valid_in_exec", {7'd0, valid}, 8'd1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_valid", {7'd0, valid}, 8'd0);
    check("t5_rst_leds", {4'd0, leds}, 8'd0);
    check("t5_rst_state", {5'd0, state}, 8'd0);
    check("t5_rst_a", {4'd0, dato_a}, 8'd0);
    btn_load = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("t5_after_state", {5'd0, state}, 8'd0);

    // 6: clear aligned with EXEC
    press_load(8'b0000_1010);
    press_load(8'b0000_0110);
    valid_snap = n_valid;
    sw = {2'b00, OP_XOR};
    btn_load = 1'b1;
    @(negedge clk);
    btn_clr = 1'b1;
    wait_exec(found);
    check("t6_exec_reached", {7'd0, found}, 8'd1);
    check("t6_valid_in_exec", {7'd0, valid}, 8'd1);
    @(negedge clk);
    check("t6_done_state", {5'd0, state}, 8'd4);
    check("t6_done_leds", {4'd0, leds}, 8'b0000_1100);
    check("t6_done_op", {2'd0, operation}, {2'd0, OP_XOR});
    @(negedge clk);
    check("t6_clr_state", {5'd0, state}, 8'd0);
    check("t6_clr_leds", {4'd0, leds}, 8'd0);
    check("t6_clr_a", {4'd0, dato_a}, 8'd0);
    check("t6_clr_b", {4'd0, dato_b}, 8'd0);
    check("t6_clr_op", {2'd0, operation}, 8'd0);
    check("t6_valid_cycles", 8'(n_valid - valid_snap), 8'd1);
    btn_load = 1'b0;
    btn_clr = 1'b0;
    repeat (10) @(negedge clk);
    check("t6_release_state", {5'd0, state}, 8'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
